// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pkg
// Brief    : Shared constants and helpers for the 7-segment scan controller.
// Revision : 1.0 - initial release
// ============================================================================
package seg7_pkg;

  localparam int MAX_DIG = 8;

  // Segments are {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry n holds the pattern for hex digit n (F first, 0 last in the literal).
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

  // Bit i set when nibble i and every more-significant nibble are zero (i != 0).
  function automatic logic [MAX_DIG-1:0] lz_mask(input logic [4*MAX_DIG-1:0] nibs,
                                                 input int ndig);
    logic all_zero;
    lz_mask  = '0;
    all_zero = 1'b1;
    for (int i = MAX_DIG - 1; i >= 1; i--) begin
      if (i < ndig) begin
        all_zero   = all_zero && (nibs[4*i +: 4] == 4'h0);
        lz_mask[i] = all_zero;
      end
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/hex7_dec.sv
`default_nettype none
// ============================================================================
// Module   : hex7_dec
// Brief    : Combinational hex nibble to active-low 7-segment pattern lookup.
// Revision : 1.0 - initial release
// ============================================================================
module hex7_dec
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nib];

endmodule
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_ctrl
// Brief    : Time-multiplexed scan driver for NDIG common-anode digits with
//            frame-aligned host updates, blink, LZ blanking and dead time.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NDIG         = 8,
  parameter int DIV          = 50000,
  parameter int DEAD         = 4,
  parameter int BLINK_FRAMES = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              upd_req,
  input  logic [4*NDIG-1:0] upd_data,
  input  logic [NDIG-1:0]   upd_en,
  input  logic [NDIG-1:0]   upd_blink,
  input  logic              lzb,
  output logic              upd_ack,
  output logic [6:0]        seg,
  output logic [NDIG-1:0]   an,
  output logic              frame_start
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = $clog2(NDIG);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PW-1:0]      r_pc;
  logic [IW-1:0]      r_idx;
  logic [FW-1:0]      r_fcnt;
  logic               r_phase;
  logic               r_frame_start;
  logic               r_ack;
  logic [4*NDIG-1:0]  r_data;
  logic [NDIG-1:0]    r_en;
  logic [NDIG-1:0]    r_blink;
  logic [6:0]         r_seg;
  logic [NDIG-1:0]    r_an;

  logic               w_tick;
  logic               w_frame_end;
  logic [3:0]         w_nib;
  logic [6:0]         w_seg;
  logic [MAX_DIG-1:0] w_lz_all;
  logic [NDIG-1:0]    w_lz;
  logic               w_unused_lz;
  logic               w_vis;
  logic               w_blank;

  assign w_tick      = (r_pc == PW'(DIV - 1));
  assign w_frame_end = w_tick && (r_idx == IW'(NDIG - 1));

  // Slot timing: prescaler, digit index and frame boundary marker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= '0;
      r_idx         <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_pc          <= w_tick ? '0 : r_pc + PW'(1);
      r_frame_start <= w_frame_end;
      if (w_tick) begin
        r_idx <= (r_idx == IW'(NDIG - 1)) ? '0 : r_idx + IW'(1);
      end
    end
  end

  // Host payload is only ever taken at a frame boundary, so a frame never mixes values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_en    <= '0;
      r_blink <= '0;
      r_ack   <= 1'b0;
    end else begin
      r_ack <= w_frame_end && upd_req;
      if (w_frame_end && upd_req) begin
        r_data  <= upd_data;
        r_en    <= upd_en;
        r_blink <= upd_blink;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fcnt  <= '0;
      r_phase <= 1'b0;
    end else if (w_frame_end) begin
      if (r_fcnt == FW'(BLINK_FRAMES - 1)) begin
        r_fcnt  <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_fcnt <= r_fcnt + FW'(1);
      end
    end
  end

  assign w_nib       = r_data[{r_idx, 2'b00} +: 4];
  assign w_lz_all    = lz_mask((4*MAX_DIG)'(r_data), NDIG);
  assign w_lz        = w_lz_all[NDIG-1:0];
  assign w_unused_lz = ^w_lz_all;

  hex7_dec u_dec (
    .nib (w_nib),
    .seg (w_seg)
  );

  assign w_vis   = r_en[r_idx] && !(r_blink[r_idx] && r_phase) && !(lzb && w_lz[r_idx]);
  assign w_blank = (r_pc < PW'(DEAD)) || !w_vis;

  // Registered pin drive; the leading dead clocks of each slot stop ghosting between digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= SEG_BLANK;
      r_an  <= '1;
    end else if (w_blank) begin
      r_seg <= SEG_BLANK;
      r_an  <= '1;
    end else begin
      r_seg <= w_seg;
      r_an  <= ~({{(NDIG-1){1'b0}}, 1'b1} << r_idx);
    end
  end

  assign seg         = r_seg;
  assign an          = r_an;
  assign upd_ack     = r_ack;
  assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_ctrl
// Brief    : Scoreboard bench for seg7_scan_ctrl (NDIG=4, DIV=4, DEAD=1, BLINK_FRAMES=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_ctrl;

  localparam int NDIG  = 4;
  localparam int DIV   = 4;
  localparam int DEAD  = 1;
  localparam int BF    = 2;
  localparam int FRAME = NDIG * DIV;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        upd_req   = 1'b0;
  logic [15:0] upd_data  = '0;
  logic [3:0]  upd_en    = '0;
  logic [3:0]  upd_blink = '0;
  logic        lzb       = 1'b0;
  logic        upd_ack;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_start;

  seg7_scan_ctrl #(
    .NDIG         (NDIG),
    .DIV          (DIV),
    .DEAD         (DEAD),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .upd_req     (upd_req),
    .upd_data    (upd_data),
    .upd_en      (upd_en),
    .upd_blink   (upd_blink),
    .lzb         (lzb),
    .upd_ack     (upd_ack),
    .seg         (seg),
    .an          (an),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // Expected frame: which digits are lit and their segment codes, digit 3 in the top 7 bits.
  typedef struct {
    int          fr;
    logic [3:0]  vis;
    logic [27:0] segs;
  } frame_t;

  frame_t frq[$];
  int     ackq[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc;
  int     fr = 0;
  int     t  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_frame(input int f, input logic [3:0] vis, input logic [27:0] segs);
    frame_t e;
    e.fr = f; e.vis = vis; e.segs = segs;
    frq.push_back(e);
  endtask

  // Monitor: frames are numbered from reset release; slot s is dead at offset 4s+1, lit at 4s+3.
  always @(negedge clk) begin : mon
    int         s;
    int         r;
    logic [3:0] ea;
    logic [6:0] es;
    if (!rst_n) begin
      fr = 0;
      t  = 0;
    end else begin
      check("an_at_most_one_low", 32'($countones(~an) > 1), 32'd0);
      if (upd_ack) begin
        if (ackq.size() == 0) check("unexpected_ack_cycle", cyc, 32'hFFFF_FFFF);
        else                  check("ack_cycle", cyc, ackq.pop_front());
      end
      if (frame_start) begin
        fr++;
        t = 0;
        check("frame_start_cycle", cyc, FRAME * fr);
      end else begin
        t++;
      end
      while (frq.size() > 0 && frq[0].fr < fr) begin
        check($sformatf("frame%0d_missed", frq[0].fr), fr, frq[0].fr);
        void'(frq.pop_front());
      end
      if (fr > 0 && t < FRAME && frq.size() > 0 && frq[0].fr == fr) begin
        s = t / DIV;
        r = t % DIV;
        if (r == 1) begin
          check($sformatf("f%0d_slot%0d_dead_an", fr, s), an, 4'hF);
          check($sformatf("f%0d_slot%0d_dead_seg", fr, s), seg, 7'h7F);
        end else if (r == 3) begin
          ea = frq[0].vis[s] ? ~(4'b0001 << s) : 4'hF;
          es = frq[0].vis[s] ? frq[0].segs[7*s +: 7] : 7'h7F;
          check($sformatf("f%0d_slot%0d_an", fr, s), an, ea);
          check($sformatf("f%0d_slot%0d_seg", fr, s), seg, es);
          if (s == NDIG - 1) void'(frq.pop_front());
        end
      end
    end
  end

  task automatic do_reset();
    rst_n   = 1'b0;
    upd_req = 1'b0;
    repeat (3) @(negedge clk);
    frq.delete();
    ackq.delete();
    rst_n = 1'b1;
  endtask

  task automatic wait_ack();
    int n = 0;
    @(negedge clk);
    while (!upd_ack && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!upd_ack) check("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic commit(input logic [15:0] d, input logic [3:0] en, input logic [3:0] bl,
                        input bit drop);
    upd_data  = d;
    upd_en    = en;
    upd_blink = bl;
    upd_req   = 1'b1;
    wait_ack();
    if (drop) upd_req = 1'b0;
  endtask

  task automatic wait_until(input int c);
    int n = 0;
    while (cyc < c && n < 1000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((frq.size() > 0 || ackq.size() > 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_frames_left", frq.size(), 32'd0);
    check("drain_acks_left", ackq.size(), 32'd0);
    repeat (FRAME) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    // Basic scan: 1A30 -> digits 0..3 show 0,3,A,1.
    do_reset();
    ackq.push_back(16);
    push_frame(1, 4'hF, {7'h79, 7'h08, 7'h30, 7'h40});
    push_frame(2, 4'hF, {7'h79, 7'h08, 7'h30, 7'h40});
    commit(16'h1A30, 4'hF, 4'h0, 1'b1);
    drain();

    // Leading-zero blanking, then an all-zero value keeps digit 0 lit.
    do_reset();
    lzb = 1'b1;
    ackq.push_back(16);
    ackq.push_back(32);
    push_frame(1, 4'b0001, {7'h7F, 7'h7F, 7'h7F, 7'h78});
    push_frame(2, 4'b0001, {7'h7F, 7'h7F, 7'h7F, 7'h40});
    push_frame(3, 4'b0001, {7'h7F, 7'h7F, 7'h7F, 7'h40});
    commit(16'h0007, 4'hF, 4'h0, 1'b1);
    repeat (2) @(negedge clk);
    commit(16'h0000, 4'hF, 4'h0, 1'b1);
    drain();
    lzb = 1'b0;

    // Tearing guard: request raised at idx=1 pc=0 waits for frame end; held req commits twice.
    do_reset();
    ackq.push_back(16);
    ackq.push_back(32);
    ackq.push_back(48);
    push_frame(1, 4'hF, {7'h79, 7'h08, 7'h30, 7'h40});
    push_frame(2, 4'hF, {7'h19, 7'h30, 7'h24, 7'h79});
    push_frame(3, 4'hF, {7'h03, 7'h06, 7'h06, 7'h0E});
    push_frame(4, 4'hF, {7'h03, 7'h06, 7'h06, 7'h0E});
    commit(16'h1A30, 4'hF, 4'h0, 1'b1);
    wait_until(20);
    commit(16'h4321, 4'hF, 4'h0, 1'b0);
    commit(16'hBEEF, 4'hF, 4'h0, 1'b1);
    drain();

    // Blink on digit 2: dark in frames 2-3, lit in frames 1, 4, 5.
    do_reset();
    ackq.push_back(16);
    push_frame(1, 4'b1111, {7'h00, 7'h19, 7'h24, 7'h79});
    push_frame(2, 4'b1011, {7'h00, 7'h19, 7'h24, 7'h79});
    push_frame(3, 4'b1011, {7'h00, 7'h19, 7'h24, 7'h79});
    push_frame(4, 4'b1111, {7'h00, 7'h19, 7'h24, 7'h79});
    push_frame(5, 4'b1111, {7'h00, 7'h19, 7'h24, 7'h79});
    commit(16'h8421, 4'hF, 4'b0100, 1'b1);
    drain();

    // Enable mask 0101: digits 1 and 3 never selected.
    do_reset();
    ackq.push_back(16);
    push_frame(1, 4'b0101, {7'h79, 7'h08, 7'h30, 7'h40});
    push_frame(2, 4'b0101, {7'h79, 7'h08, 7'h30, 7'h40});
    commit(16'h1A30, 4'b0101, 4'h0, 1'b1);
    drain();

    // Mid-slot asynchronous reset with a pending request: no ack, outputs blank at once.
    do_reset();
    ackq.push_back(16);
    commit(16'h1A30, 4'hF, 4'h0, 1'b1);
    wait_until(20);
    upd_data = 16'h2222;
    upd_req  = 1'b1;
    wait_until(24);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_seg", seg, 7'h7F);
    check("async_reset_an", an, 4'hF);
    check("async_reset_ack", upd_ack, 1'b0);
    check("async_reset_frame_start", frame_start, 1'b0);
    @(negedge clk);
    upd_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push_frame(1, 4'b0000, {7'h7F, 7'h7F, 7'h7F, 7'h7F});
    push_frame(2, 4'b0000, {7'h7F, 7'h7F, 7'h7F, 7'h7F});
    ackq.push_back(48);
    push_frame(3, 4'hF, {7'h24, 7'h24, 7'h24, 7'h24});
    wait_until(34);
    commit(16'h2222, 4'hF, 4'h0, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
